// File: rtl/gray_window_3x3_if.sv
// Pixel-stream / window bundle for gray_window_3x3.
// The master drives pixels in; the slave (the window generator) drives windows out.
interface gray_window_3x3_if #(
  parameter int PIX_W = 8
) ();
  logic [PIX_W-1:0]   pix_in;
  logic               pix_valid;
  logic               sof;
  logic [9*PIX_W-1:0] win_data;
  logic               win_valid;
  logic               win_last;

  modport master (
    output pix_in, pix_valid, sof,
    input  win_data, win_valid, win_last
  );

  modport slave (
    input  pix_in, pix_valid, sof,
    output win_data, win_valid, win_last
  );
endinterface

// File: rtl/gray_window_3x3.sv
// Line-buffered 3x3 "valid-mode" window generator for a raster grayscale stream.
// Optional macro GRAY_WINDOW_COORD_EN adds win_x/win_y (window centre coordinates).
module gray_window_3x3 #(
  parameter int IMG_W = 160,
  parameter int IMG_H = 120,
  parameter int PIX_W = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  gray_window_3x3_if.slave           win_if
`ifdef GRAY_WINDOW_COORD_EN
  ,
  output logic [$clog2(IMG_W)-1:0]   win_x,
  output logic [$clog2(IMG_H)-1:0]   win_y
`endif
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  logic                accept;
  logic [CW-1:0]       col_q, col_d, cur_col;
  logic [RW-1:0]       row_q, row_d, cur_row;

  logic [PIX_W-1:0]    lb1_q [IMG_W];
  logic [PIX_W-1:0]    lb2_q [IMG_W];
  logic [PIX_W-1:0]    lb1_rd, lb2_rd;

  logic [PIX_W-1:0]    top_q [3];
  logic [PIX_W-1:0]    top_d [3];
  logic [PIX_W-1:0]    mid_q [3];
  logic [PIX_W-1:0]    mid_d [3];
  logic [PIX_W-1:0]    bot_q [3];
  logic [PIX_W-1:0]    bot_d [3];

  logic [9*PIX_W-1:0]  win_data_q, win_data_d;
  logic                win_valid_q, win_valid_d;
  logic                win_last_q, win_last_d;
  logic [CW-1:0]       win_x_q, win_x_d;
  logic [RW-1:0]       win_y_q, win_y_d;

  assign accept = win_if.pix_valid;

  // A qualified sof forces the current pixel to (0,0) whatever the counters say.
  always_comb begin
    cur_col = col_q;
    cur_row = row_q;
    if (accept && win_if.sof) begin
      cur_col = '0;
      cur_row = '0;
    end else begin
      cur_col = col_q;
      cur_row = row_q;
    end
  end

  assign lb1_rd = lb1_q[cur_col];
  assign lb2_rd = lb2_q[cur_col];

  // Next-state: position counters, column shift registers and the output window.
  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    top_d       = top_q;
    mid_d       = mid_q;
    bot_d       = bot_q;
    win_data_d  = win_data_q;
    win_valid_d = 1'b0;
    win_last_d  = 1'b0;
    win_x_d     = win_x_q;
    win_y_d     = win_y_q;
    if (accept) begin
      if (cur_col == COL_LAST) begin
        col_d = '0;
        if (cur_row == ROW_LAST) begin
          row_d = '0;
        end else begin
          row_d = cur_row + RW'(1);
        end
      end else begin
        col_d = cur_col + CW'(1);
        row_d = cur_row;
      end

      // Index 0 is the oldest (leftmost) column, index 2 the column just read.
      top_d[0] = top_q[1];
      top_d[1] = top_q[2];
      top_d[2] = lb2_rd;
      mid_d[0] = mid_q[1];
      mid_d[1] = mid_q[2];
      mid_d[2] = lb1_rd;
      bot_d[0] = bot_q[1];
      bot_d[1] = bot_q[2];
      bot_d[2] = win_if.pix_in;

      if ((cur_row >= ROW_TWO) && (cur_col >= COL_TWO)) begin
        win_valid_d = 1'b1;
        win_last_d  = (cur_col == COL_LAST) && (cur_row == ROW_LAST);
        win_data_d  = {bot_d[2], bot_d[1], bot_d[0],
                       mid_d[2], mid_d[1], mid_d[0],
                       top_d[2], top_d[1], top_d[0]};
        win_x_d     = cur_col - CW'(1);
        win_y_d     = cur_row - RW'(1);
      end else begin
        win_valid_d = 1'b0;
        win_last_d  = 1'b0;
      end
    end else begin
      win_valid_d = 1'b0;
      win_last_d  = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      col_q       <= '0;
      row_q       <= '0;
      top_q       <= '{default: '0};
      mid_q       <= '{default: '0};
      bot_q       <= '{default: '0};
      win_data_q  <= '0;
      win_valid_q <= 1'b0;
      win_last_q  <= 1'b0;
      win_x_q     <= '0;
      win_y_q     <= '0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      top_q       <= top_d;
      mid_q       <= mid_d;
      bot_q       <= bot_d;
      win_data_q  <= win_data_d;
      win_valid_q <= win_valid_d;
      win_last_q  <= win_last_d;
      win_x_q     <= win_x_d;
      win_y_q     <= win_y_d;
    end
  end

  // Line RAMs are never cleared; reads above see the old contents this cycle.
  always_ff @(posedge clock) begin
    if (accept) begin
      lb2_q[cur_col] <= lb1_rd;
      lb1_q[cur_col] <= win_if.pix_in;
    end
  end

  assign win_if.win_data  = win_data_q;
  assign win_if.win_valid = win_valid_q;
  assign win_if.win_last  = win_last_q;

`ifdef GRAY_WINDOW_COORD_EN
  assign win_x = win_x_q;
  assign win_y = win_y_q;
`else
  logic unused_coord;
  assign unused_coord = ^{win_x_q, win_y_q};
`endif

endmodule

// File: tb/tb_gray_window_3x3.sv
// Directed bench for gray_window_3x3 on a 4x4 image with pixel = 16*row+col.
module tb_gray_window_3x3;
  localparam int IMG_W = 4;
  localparam int IMG_H = 4;
  localparam int PIX_W = 8;
  localparam int NPIX  = IMG_W * IMG_H;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  gray_window_3x3_if #(.PIX_W(PIX_W)) win_if ();

`ifdef GRAY_WINDOW_COORD_EN
  logic [1:0] win_x;
  logic [1:0] win_y;
`endif

  gray_window_3x3 #(.IMG_W(IMG_W), .IMG_H(IMG_H), .PIX_W(PIX_W)) dut (
    .clock  (clock),
    .reset  (reset),
    .win_if (win_if)
`ifdef GRAY_WINDOW_COORD_EN
    ,
    .win_x  (win_x),
    .win_y  (win_y)
`endif
  );

  typedef struct {
    logic [7:0]  pix;
    logic        sof;
    logic        exp_valid;
    logic        exp_last;
    logic [71:0] exp_data;
    logic [1:0]  exp_x;
    logic [1:0]  exp_y;
  } vec_t;

  vec_t tbl [NPIX];
  int checks = 0;
  int errors = 0;
  int n_win  = 0;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic [7:0] pix, input logic sof, input logic valid);
    win_if.pix_in    = pix;
    win_if.sof       = sof;
    win_if.pix_valid = valid;
    @(posedge clock);
    #1;
    if (win_if.win_valid === 1'b1) n_win++;
  endtask

  task automatic run_frame(input logic [7:0] offset, input logic use_sof,
                           input logic gap, input string tag);
    logic [71:0] held;
    n_win = 0;
    for (int i = 0; i < NPIX; i++) begin
      step(tbl[i].pix | offset, tbl[i].sof & use_sof, 1'b1);
      check({tag, " valid"}, 72'(win_if.win_valid), 72'(tbl[i].exp_valid));
      check({tag, " last"}, 72'(win_if.win_last), 72'(tbl[i].exp_last));
      if (tbl[i].exp_valid) begin
        check({tag, " data"}, win_if.win_data, tbl[i].exp_data | {9{offset}});
`ifdef GRAY_WINDOW_COORD_EN
        check({tag, " win_x"}, 72'(win_x), 72'(tbl[i].exp_x));
        check({tag, " win_y"}, 72'(win_y), 72'(tbl[i].exp_y));
`endif
      end
      if (gap) begin
        held = win_if.win_data;
        step(8'hEE, 1'b1, 1'b0);
        check({tag, " idle valid"}, 72'(win_if.win_valid), 72'd0);
        check({tag, " idle hold"}, win_if.win_data, held);
      end
    end
    check({tag, " window count"}, 72'(n_win), 72'd4);
  endtask

  initial begin
    for (int r = 0; r < IMG_H; r++) begin
      for (int c = 0; c < IMG_W; c++) begin
        tbl[4*r+c].pix       = 8'(16*r + c);
        tbl[4*r+c].sof       = (r == 0) && (c == 0);
        tbl[4*r+c].exp_valid = 1'b0;
        tbl[4*r+c].exp_last  = 1'b0;
        tbl[4*r+c].exp_data  = 72'h0;
        tbl[4*r+c].exp_x     = 2'd0;
        tbl[4*r+c].exp_y     = 2'd0;
      end
    end
    tbl[10].exp_valid = 1'b1; tbl[10].exp_data = 72'h22_21_20_12_11_10_02_01_00;
    tbl[10].exp_x = 2'd1;     tbl[10].exp_y = 2'd1;
    tbl[11].exp_valid = 1'b1; tbl[11].exp_data = 72'h23_22_21_13_12_11_03_02_01;
    tbl[11].exp_x = 2'd2;     tbl[11].exp_y = 2'd1;
    tbl[14].exp_valid = 1'b1; tbl[14].exp_data = 72'h32_31_30_22_21_20_12_11_10;
    tbl[14].exp_x = 2'd1;     tbl[14].exp_y = 2'd2;
    tbl[15].exp_valid = 1'b1; tbl[15].exp_data = 72'h33_32_31_23_22_21_13_12_11;
    tbl[15].exp_x = 2'd2;     tbl[15].exp_y = 2'd2;
    tbl[15].exp_last  = 1'b1;

    reset            = 1'b1;
    win_if.pix_in    = 8'h00;
    win_if.sof       = 1'b0;
    win_if.pix_valid = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1;
    check("reset valid", 72'(win_if.win_valid), 72'd0);
    check("reset last", 72'(win_if.win_last), 72'd0);
    check("reset data", win_if.win_data, 72'h0);
`ifdef GRAY_WINDOW_COORD_EN
    check("reset win_x", 72'(win_x), 72'd0);
    check("reset win_y", 72'(win_y), 72'd0);
`endif
    reset = 1'b0;

    run_frame(8'h00, 1'b1, 1'b0, "frame");
    run_frame(8'h00, 1'b1, 1'b1, "gapped");
    run_frame(8'h00, 1'b1, 1'b0, "pair1");
    run_frame(8'h80, 1'b1, 1'b0, "pair2");

    // Abort a frame after six pixels with a fresh sof on the seventh.
    n_win = 0;
    for (int i = 0; i < 6; i++) begin
      step(8'hF0 | 8'(i), (i == 0), 1'b1);
    end
    check("pre-restart windows", 72'(n_win), 72'd0);
    run_frame(8'h00, 1'b1, 1'b0, "restart");

    // Reset after nine pixels, then a frame with no sof at all.
    for (int i = 0; i < 9; i++) begin
      step(8'h40 | 8'(i), (i == 0), 1'b1);
    end
    reset            = 1'b1;
    win_if.pix_valid = 1'b0;
    win_if.sof       = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    check("post-reset valid", 72'(win_if.win_valid), 72'd0);
    check("post-reset data", win_if.win_data, 72'h0);
    run_frame(8'h00, 1'b0, 1'b0, "nosof");

    win_if.pix_valid = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
